// File: rtl/data_sram_bridge_pkg.sv
// -----------------------------------------------------------------------------
// data_sram_bridge_pkg
// Shared definitions for the data-side SRAM bridge:
//   - FSM state encoding (IDLE / ISSUE / WAIT / RESP)
//   - request-queue entry field widths (the address field width is a bridge
//     parameter, so only the fixed-width fields live here)
//   - seed and step function of the optional random-stall LFSR
// -----------------------------------------------------------------------------
package data_sram_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } dsb_state_e;

    // Queue entry layout, MSB first: {wr, wstrb, word_addr, wdata}
    localparam int DSB_WR_W    = 1;
    localparam int DSB_WSTRB_W = 4;
    localparam int DSB_DATA_W  = 32;

    localparam logic [15:0] DSB_LFSR_SEED = 16'hACE1;

    // Fibonacci LFSR, taps 16/14/13/11 (maximal length), shifting right.
    function automatic logic [15:0] dsb_lfsr_next(input logic [15:0] s);
        logic fb;
        fb = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {fb, s[15:1]};
    endfunction

endpackage

// File: rtl/data_sram_bridge_fifo.sv
// -----------------------------------------------------------------------------
// dsb_req_fifo
// Small request queue of DEPTH entries (DEPTH a power of two, >= 2).
// Pointers carry one extra wrap bit so full and empty are distinguishable.
// The head is read asynchronously: the FSM needs the head entry in the same
// cycle the pointer moves, and the queue is only a handful of entries deep.
// Ports:
//   clk, reset         clock, synchronous active-high reset (empties queue)
//   push, din          write din at the tail (caller guarantees !full)
//   pop                drop the head entry (caller guarantees !empty)
//   full, empty        occupancy flags
//   head               current head entry
//   count              current occupancy
// -----------------------------------------------------------------------------
module dsb_req_fifo #(
    parameter int W     = 53,
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic                     full,
    output logic                     empty,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

    logic [W-1:0] mem_reg [DEPTH];
    logic [PW:0]  wr_ptr_reg;
    logic [PW:0]  rd_ptr_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Entry storage is not reset; validity is tracked by the pointers alone.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg[PW-1:0]] <= din;
        end
    end

    assign head  = mem_reg[rd_ptr_reg[PW-1:0]];
    assign count = wr_ptr_reg - rd_ptr_reg;
    assign empty = (wr_ptr_reg == rd_ptr_reg);
    assign full  = (wr_ptr_reg[PW] != rd_ptr_reg[PW]) &&
                   (wr_ptr_reg[PW-1:0] == rd_ptr_reg[PW-1:0]);

endmodule

// File: rtl/data_sram_bridge.sv
// -----------------------------------------------------------------------------
// data_sram_bridge
// Bridges the CPU MEM-stage request/response handshake onto a simple
// synchronous SRAM port with a fixed read latency of LAT cycles.
// Requests are queued (QDEPTH entries) and serviced strictly in order by a
// four-state FSM: IDLE -> ISSUE -> (WAIT x LAT-1) -> RESP.
// Build option: define DSB_RAND_DELAY_EN to add an LFSR-driven stall that
// throttles request acceptance and occasionally holds the FSM in IDLE.
// Parameters: RAM_AW (word-address width), QDEPTH (queue depth), LAT (1..4)
// Ports:
//   clk, reset                          clock, synchronous active-high reset
//   data_req/wr/size/wstrb/addr/wdata   request from MEM stage
//   data_addr_ok                        request accepted this cycle
//   data_data_ok, data_rdata            one-cycle response pulse and data
//   ram_en/wen/addr/wdata               SRAM command (valid in ISSUE only)
//   ram_rdata                           SRAM read data, LAT cycles after ram_en
// -----------------------------------------------------------------------------
module data_sram_bridge
    import data_sram_bridge_pkg::*;
#(
    parameter int RAM_AW = 16,
    parameter int QDEPTH = 2,
    parameter int LAT    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [31:0]       data_addr,
    input  logic [31:0]       data_wdata,
    output logic              data_addr_ok,
    output logic [31:0]       data_rdata,
    output logic              data_data_ok,
    output logic              ram_en,
    output logic [3:0]        ram_wen,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);
    localparam int EW = DSB_WR_W + DSB_WSTRB_W + RAM_AW + DSB_DATA_W;
    localparam int CW = $clog2(QDEPTH) + 1;
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [2:0]    LAT_M1  = 3'(LAT - 1);

    // ---------------------------------------------------------------- stall
    logic stall;
`ifdef DSB_RAND_DELAY_EN
    logic [15:0] lfsr_reg;
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_reg <= DSB_LFSR_SEED;
        end else begin
            lfsr_reg <= dsb_lfsr_next(lfsr_reg);
        end
    end
    assign stall = lfsr_reg[0];
`else
    assign stall = 1'b0;
`endif

    // ---------------------------------------------------------------- queue
    logic          q_full;
    logic          q_empty;
    logic          q_push;
    logic          q_pop;
    logic [EW-1:0] q_din;
    logic [EW-1:0] q_head;
    logic [CW-1:0] q_count;

    dsb_state_e    state_reg;
    logic [2:0]    cnt_reg;

    // Acceptance only looks at the registered full flag, never at a pop
    // happening in the same cycle, which keeps addr_ok off the FSM path.
    assign data_addr_ok = data_req & ~q_full & ~stall & ~reset;
    assign q_push       = data_addr_ok;
    assign q_pop        = (state_reg == ST_RESP);
    // Word address keeps only RAM_AW bits, so it wraps modulo 2^RAM_AW.
    assign q_din        = {data_wr, data_wstrb, data_addr[RAM_AW+1:2], data_wdata};

    dsb_req_fifo #(
        .W     (EW),
        .DEPTH (QDEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .din   (q_din),
        .full  (q_full),
        .empty (q_empty),
        .head  (q_head),
        .count (q_count)
    );

    logic              head_wr;
    logic [3:0]        head_wstrb;
    logic [RAM_AW-1:0] head_addr;
    logic [31:0]       head_wdata;

    assign head_wr    = q_head[EW-1];
    assign head_wstrb = q_head[EW-2 -: DSB_WSTRB_W];
    assign head_addr  = q_head[DSB_DATA_W +: RAM_AW];
    assign head_wdata = q_head[DSB_DATA_W-1:0];

    // Only the request size is informational; the high/low address bits
    // outside the word address are deliberately ignored.
    logic unused_inputs;
    assign unused_inputs = ^{data_size, data_addr[31:RAM_AW+2], data_addr[1:0]};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 3'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (!q_empty && !stall) begin
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (LAT == 1) begin
                        state_reg <= ST_RESP;
                    end else begin
                        state_reg <= ST_WAIT;
                        cnt_reg   <= LAT_M1;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_reg - 3'd1;
                    if (cnt_reg == 3'd1) begin
                        state_reg <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    // Head is popped on this edge; a same-cycle push also
                    // counts as a remaining entry.
                    if ((q_count != CNT_ONE) || q_push) begin
                        state_reg <= ST_ISSUE;
                    end else begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------- outputs
    // All outputs are pure decodes of the state register and the queue head,
    // forced to zero while reset is high.
    logic in_issue;
    logic in_resp;

    assign in_issue = (state_reg == ST_ISSUE) && !reset;
    assign in_resp  = (state_reg == ST_RESP)  && !reset;

    assign ram_en    = in_issue;
    assign ram_wen   = (in_issue && head_wr) ? head_wstrb : 4'b0000;
    assign ram_addr  = in_issue ? head_addr  : '0;
    assign ram_wdata = in_issue ? head_wdata : 32'h0;

    // The SRAM's own output register (LAT stages after ISSUE) is the response
    // register: its value lands exactly in the RESP cycle, so it is steered
    // straight to data_rdata there, and zeroed for writes.
    assign data_data_ok = in_resp;
    assign data_rdata   = (in_resp && !head_wr) ? ram_rdata : 32'h0;

endmodule
